led_trail_pwm: RTL

- Downstream stage of the LED walker: consumes the walker's one-hot 8-bit LED vector and drives the physical LED pins.
- Each LED that was recently lit keeps a brightness level. The level decays after the walker moves on, giving a fading "comet tail".
- Brightness is rendered by per-LED PWM against a shared free-running counter.
- The block sits between the walker output and the board LED pins.

---
 rtl/led_trail_pwm.sv | 94 +++++++++
 1 files changed

// File: rtl/led_trail_pwm.sv
// led_trail_pwm: per-LED fading brightness with PWM rendering for the LED walker output.
// Define LEDTRAIL_GAMMA_EN to render brightness through a gamma lookup instead of linearly.
module led_trail_pwm #(
  parameter int unsigned NLEDS      = 8,
  parameter int unsigned DECAY_CLKS = 750_000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [NLEDS-1:0] i_led,
  output logic [NLEDS-1:0] o_led,
  output logic             o_active
);

  localparam int unsigned DCW = 24;
  localparam int unsigned LW  = 4;
  localparam int unsigned PW  = 4;

  localparam logic [DCW-1:0] DECAY_RELOAD = DCW'(DECAY_CLKS - 1);
  localparam logic [PW-1:0]  PWM_LAST     = PW'(14);
  localparam logic [LW-1:0]  LEVEL_MAX    = LW'(15);

  logic [DCW-1:0]            decay_cnt_q, decay_cnt_d;
  logic                      decay_stb_c;
  logic [PW-1:0]             pwm_cnt_q, pwm_cnt_d;
  logic [NLEDS-1:0][LW-1:0]  level_q, level_d;
  logic [NLEDS-1:0][LW-1:0]  eff_c;
  logic [NLEDS-1:0]          o_led_q, o_led_d;
  logic                      active_q, active_d;

`ifdef LEDTRAIL_GAMMA_EN
  // Perceptual brightness curve; end points 0 and 15 map to themselves.
  function automatic logic [LW-1:0] gamma_lut(input logic [LW-1:0] lvl);
    logic [LW-1:0] g;
    case (lvl)
      4'd0, 4'd1, 4'd2: g = 4'd0;
      4'd3, 4'd4, 4'd5: g = 4'd1;
      4'd6, 4'd7:       g = 4'd2;
      4'd8:             g = 4'd3;
      4'd9:             g = 4'd4;
      4'd10:            g = 4'd5;
      4'd11:            g = 4'd6;
      4'd12:            g = 4'd8;
      4'd13:            g = 4'd10;
      4'd14:            g = 4'd12;
      default:          g = 4'd15;
    endcase
    return g;
  endfunction
`endif

  // Prescaler, PWM ramp, per-LED level update and output compare.
  always_comb begin
    decay_stb_c = (decay_cnt_q == '0);
    decay_cnt_d = decay_stb_c ? DECAY_RELOAD : decay_cnt_q - DCW'(1);
    pwm_cnt_d   = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + PW'(1);
    level_d     = level_q;
    eff_c       = level_q;
    o_led_d     = '0;
    active_d    = 1'b0;
    for (int unsigned k = 0; k < NLEDS; k++) begin
`ifdef LEDTRAIL_GAMMA_EN
      eff_c[k] = gamma_lut(level_q[k]);
`endif
      o_led_d[k] = (eff_c[k] > pwm_cnt_q);
      active_d   = active_d | (level_q[k] != '0);
      // Refresh wins over a coincident decay step.
      if (i_led[k]) begin
        level_d[k] = LEVEL_MAX;
      end else if (decay_stb_c && (level_q[k] != '0)) begin
        level_d[k] = level_q[k] - LW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      decay_cnt_q <= DECAY_RELOAD;
      pwm_cnt_q   <= '0;
      level_q     <= '0;
      o_led_q     <= '0;
      active_q    <= 1'b0;
    end else begin
      decay_cnt_q <= decay_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      level_q     <= level_d;
      o_led_q     <= o_led_d;
      active_q    <= active_d;
    end
  end

  assign o_led    = o_led_q;
  assign o_active = active_q;

endmodule
